uart_imem_loader: RTL and testbench

- Serial program loader: receives a binary image over UART (8N1) and writes it word by word into instruction memory.
- It is the writer side of the instruction-memory interface that the CPU's instruction fetch reads.
- While loading, `busy` holds the CPU in reset. After `done`, the CPU runs from word address 0.
- Contains a UART byte receiver plus a framing/assembly FSM.

---
 rtl/uart_imem_loader_pkg.sv | 23 ++
 rtl/uart_imem_loader_rx.sv | 106 ++++++++++
 rtl/uart_imem_loader.sv | 153 +++++++++++++++
 tb/tb_uart_imem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared widths and state encodings for the UART instruction-memory loader.
package uart_imem_loader_pkg;

    localparam int REGWIDTH  = 32;
    localparam int INSTWIDTH = 32;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        L_IDLE = 3'd0,
        L_LEN0 = 3'd1,
        L_LEN1 = 3'd2,
        L_DATA = 3'd3,
        L_DONE = 3'd4,
        L_ERR  = 3'd5
    } ld_state_e;

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling timer and RX FSM.
module uart_rx_byte
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             rx_s;
    logic             rx_fall;

    // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detection.
    assign rx_s    = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RX_IDLE;
            sync_q        <= 3'b111;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[1:0], rx_i};
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d         = '0;
                    byte_valid_d  = rx_s;
                    frame_error_d = ~rx_s;
                    state_d       = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o        = shift_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_error_o = frame_error_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Serial program loader: length-prefixed little-endian image over UART into instruction memory.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [INSTWIDTH-1:0]  imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int WC_W         = ADDR_WIDTH + 1;

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        frame_error;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (uart_rx),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_error_o(frame_error)
    );

    ld_state_e             state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [WC_W-1:0]       len_q, len_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           wbuf_q, wbuf_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSTWIDTH-1:0]  wdata_q, wdata_d;
    logic [WC_W-1:0]       wc_q, wc_d;
    logic [15:0]           len_full;
    logic [WC_W-1:0]       wc_inc;

    assign len_full = {rx_byte, len_lo_q};
    assign wc_inc   = wc_q + 1'b1;

    // NOTE: the byte buffer and write-data register are plain flops, so reset clears them to 0 too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= L_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            wbuf_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wc_q       <= '0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            wbuf_q     <= wbuf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wc_q       <= wc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        wbuf_d     = wbuf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wc_d       = wc_q;
        case (state_q)
            L_IDLE, L_DONE, L_ERR: begin
                if (start) begin
                    state_d    = L_LEN0;
                    wc_d       = '0;
                    byte_idx_d = '0;
                end
            end
            L_LEN0: begin
                if (frame_error) begin
                    state_d = L_ERR;
                end else if (byte_valid) begin
                    len_lo_d = rx_byte;
                    state_d  = L_LEN1;
                end
            end
            L_LEN1: begin
                if (frame_error) begin
                    state_d = L_ERR;
                end else if (byte_valid) begin
                    if (len_full == 16'd0) begin
                        state_d = L_DONE;
                    end else if ({16'd0, len_full} > (32'd1 << ADDR_WIDTH)) begin
                        state_d = L_ERR;
                    end else begin
                        len_d   = WC_W'(len_full);
                        state_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (frame_error) begin
                    state_d = L_ERR;
                end else if (byte_valid) begin
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = wc_q[ADDR_WIDTH-1:0];
                        wdata_d    = {rx_byte, wbuf_q};
                        wc_d       = wc_inc;
                        byte_idx_d = '0;
                        if (wc_inc == len_q) state_d = L_DONE;
                    end else begin
                        case (byte_idx_q)
                            2'd0:    wbuf_d[7:0]   = rx_byte;
                            2'd1:    wbuf_d[15:8]  = rx_byte;
                            default: wbuf_d[23:16] = rx_byte;
                        endcase
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = wc_q;
    assign busy       = (state_q == L_LEN0) || (state_q == L_LEN1) || (state_q == L_DATA);
    assign done       = (state_q == L_DONE);
    assign err        = (state_q == L_ERR);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: UART byte streams checked against a length/word-level image model.
module tb_uart_imem_loader;

    localparam int AW   = 14;
    localparam int AW_S = 2;
    localparam int CPB  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;
    logic start = 1'b0;

    logic          imem_we, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    logic            s_we, s_busy, s_done, s_err;
    logic [AW_S-1:0] s_addr;
    logic [31:0]     s_wdata;
    logic [AW_S:0]   s_wc;

    int total = 0;
    int bad = 0;

    int          wa[$];
    logic [31:0] wd[$];
    int          sa[$];
    logic [31:0] sd[$];
    logic        we_prev = 1'b0;
    logic        post_done = 1'b0;
    logic        post_busy = 1'b0;

    logic [7:0]  stim[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done, exp_err;
    int          exp_wc;

    always #5 clk = ~clk;

    uart_imem_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .start(start),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    uart_imem_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_WIDTH(AW_S)) dut_s (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .start(start),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .err(s_err), .word_count(s_wc)
    );

    // Write monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(imem_wdata);
        end
        if (s_we) begin
            sa.push_back(int'(s_addr));
            sd.push_back(s_wdata);
        end
        if (we_prev) begin
            post_done <= done;
            post_busy <= busy;
        end
        we_prev <= imem_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB - 1) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        wa.delete(); wd.delete(); sa.delete(); sd.delete();
    endtask

    // Image model: 16-bit LE length, then N little-endian words; anything after is ignored.
    task automatic model(input int cap);
        int n;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_wc   = 0;
        n = int'(stim[0]) + 256 * int'(stim[1]);
        if (n == 0) begin
            exp_done = 1'b1;
        end else if (n > cap) begin
            exp_err = 1'b1;
        end else begin
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(w);
                exp_data.push_back({stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]});
            end
            exp_done = 1'b1;
            exp_wc   = n;
        end
    endtask

    task automatic run_image(input string name, input bit mid_start);
        clear_mon();
        pulse_start();
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], 1'b1);
            if (mid_start && i == 2) pulse_start();
        end
        repeat (20) @(negedge clk);

        model(1 << AW);
        total++;
        if (wa.size() != exp_addr.size()) begin
            bad++;
            $display("FAIL %s write count: got %0d want %0d", name, wa.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < wa.size(); i++) begin
                total++;
                if (wa[i] !== exp_addr[i] || wd[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL %s write %0d: got %0d:%h want %0d:%h",
                             name, i, wa[i], wd[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        total++;
        if ({done, err, busy} !== {exp_done, exp_err, 1'b0}) begin
            bad++;
            $display("FAIL %s flags done/err/busy: got %b%b%b want %b%b0",
                     name, done, err, busy, exp_done, exp_err);
        end
        total++;
        if (word_count !== (AW+1)'(exp_wc)) begin
            bad++;
            $display("FAIL %s word_count: got %0d want %0d", name, word_count, exp_wc);
        end
        if (exp_addr.size() > 0) begin
            total++;
            if (post_done !== 1'b1 || post_busy !== 1'b0) begin
                bad++;
                $display("FAIL %s after last write done/busy: got %b/%b want 1/0",
                         name, post_done, post_busy);
            end
        end

        model(1 << AW_S);
        total++;
        if (sa.size() != exp_addr.size()) begin
            bad++;
            $display("FAIL %s small write count: got %0d want %0d", name, sa.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < sa.size(); i++) begin
                total++;
                if (sa[i] !== exp_addr[i] || sd[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL %s small write %0d: got %0d:%h want %0d:%h",
                             name, i, sa[i], sd[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        total++;
        if ({s_done, s_err, s_busy} !== {exp_done, exp_err, 1'b0} || s_wc !== (AW_S+1)'(exp_wc)) begin
            bad++;
            $display("FAIL %s small done/err/busy/wc: got %b%b%b/%0d want %b%b0/%0d",
                     name, s_done, s_err, s_busy, s_wc, exp_done, exp_err, exp_wc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({imem_we, busy, done, err} !== 4'b0 || imem_addr !== '0 || imem_wdata !== '0 || word_count !== '0) begin
            bad++;
            $display("FAIL reset outputs: got we=%b busy=%b done=%b err=%b addr=%h wdata=%h wc=%0d want all 0",
                     imem_we, busy, done, err, imem_addr, imem_wdata, word_count);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({imem_we, busy, done, err, s_busy, s_done, s_err} !== 7'b0) begin
            bad++;
            $display("FAIL idle after reset flags: got we=%b busy=%b done=%b err=%b want 0",
                     imem_we, busy, done, err);
        end
    endtask

    task automatic test_normal();
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        run_image("normal", 1'b1);
        total++;
        if (wd.size() != 2 || wd[0] !== 32'h00100093 || wd[1] !== 32'h00200113) begin
            bad++;
            $display("FAIL normal words: got %0d writes want 00100093,00200113", wd.size());
        end
    endtask

    task automatic test_zero_len();
        stim = '{8'h00, 8'h00, 8'h5A};
        run_image("zero_len", 1'b0);
    endtask

    task automatic test_frame_error();
        clear_mon();
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        repeat (20) @(negedge clk);
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || wa.size() != 0) begin
            bad++;
            $display("FAIL frame_error: got err=%b busy=%b writes=%0d want 1/0/0", err, busy, wa.size());
        end
        stim = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_image("frame_recover", 1'b0);
        total++;
        if (wd.size() != 1 || wd[0] !== 32'h12345678 || err !== 1'b0) begin
            bad++;
            $display("FAIL frame_recover word: got %0d writes err=%b want 12345678 err=0", wd.size(), err);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++;
        if (busy !== 1'b1 || wa.size() != 0) begin
            bad++;
            $display("FAIL glitch mid-word: got busy=%b writes=%0d want 1/0", busy, wa.size());
        end
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        repeat (20) @(negedge clk);
        total++;
        if (wa.size() != 1 || wd[0] !== 32'hDDCCBBAA || done !== 1'b1) begin
            bad++;
            $display("FAIL glitch word: got %0d writes done=%b want one DDCCBBAA done=1", wa.size(), done);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({imem_we, busy, done, err} !== 4'b0 || imem_addr !== '0 || imem_wdata !== '0 || word_count !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs: got we=%b busy=%b done=%b err=%b addr=%h wdata=%h wc=%0d want all 0",
                     imem_we, busy, done, err, imem_addr, imem_wdata, word_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h33 + 8'(i), 1'b1);
        repeat (20) @(negedge clk);
        total++;
        if (wa.size() != 0 || sa.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid later bytes: got writes=%0d busy=%b want 0/0", wa.size(), busy);
        end
    endtask

    task automatic test_overflow();
        stim = '{8'h05, 8'h00};
        for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
        run_image("overflow5", 1'b0);
        stim = '{8'h04, 8'h00};
        for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
        run_image("full4", 1'b0);
    endtask

    task automatic test_random();
        int n;
        int extra;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 5));
            extra = int'($urandom_range(0, 2));
            stim.delete();
            stim.push_back(8'(n));
            stim.push_back(8'h00);
            for (int k = 0; k < 4 * n + extra; k++) stim.push_back(8'($urandom));
            run_image($sformatf("random%0d", it), n <= 4);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_len();
        test_frame_error();
        test_glitch();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
